lfsr_word_arbiter: RTL and testbench

Controller and arbiter for the 16-bit Fibonacci LFSR random source. It holds the LFSR in its seed state and sequences it. It guarantees every handed-out word has been fully refreshed by at least REFRESH shifts of ring-oscillator-mixed bits since the previous word, and shares those words between N_REQ requesters with round-robin fairness. It sits between the ring-oscillator/LFSR pair and the consumers of random words.

---
 rtl/lfsr_word_arbiter_if.sv | 32 +++
 rtl/lfsr_word_arbiter.sv | 150 +++++++++++++++
 tb/tb_lfsr_word_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_word_arbiter_if.sv
// Consumer-side bus of the LFSR word arbiter: per-requester request levels in,
// one-hot grant pulse, valid strobe and the random word out.
//   req   : requester -> arbiter, level held until granted
//   grant : arbiter -> requesters, one-hot single-cycle pulse
//   valid : arbiter -> requesters, high exactly while grant is non-zero
//   data  : arbiter -> requesters, random word, bit order [0:15]
interface lfsr_word_arbiter_if #(
  parameter int unsigned N_REQ = 4
) ();

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic             valid;
  logic [0:15]      data;

  // Requester side
  modport master (
    output req,
    input  grant,
    input  valid,
    input  data
  );

  // Arbiter side
  modport slave (
    input  req,
    output grant,
    output valid,
    output data
  );

endinterface

// File: rtl/lfsr_word_arbiter.sv
// Controller/arbiter for a 16-bit Fibonacci LFSR random source. Holds the LFSR
// in reset while seeding, lets it shift at least REFRESH times between two
// handed-out words, and shares words between N_REQ requesters round-robin.
// Ports:
//   CLK        : system clock, rising edge
//   reset_n    : synchronous active-low reset
//   reseed     : single-cycle pulse, restarts seeding and discards freshness
//   lfsr_out   : LFSR state, bit order [0:15]
//   lfsr_reset : registered active-high reset to the LFSR
//   bus        : slave side of lfsr_word_arbiter_if (req/grant/valid/data)
module lfsr_word_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned REFRESH = 16
) (
  input  logic                CLK,
  input  logic                reset_n,
  input  logic                reseed,
  input  logic [0:15]         lfsr_out,
  output logic                lfsr_reset,
  lfsr_word_arbiter_if.slave  bus
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                lfsr_reset_q, lfsr_reset_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                valid_q, valid_d;
  logic [0:WORD_W-1]   data_q, data_d;

  logic [N_REQ-1:0]    req_s;
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    win_next;

  assign req_s = bus.req;

  // Round-robin search: first set request at or above ptr_q, wrapping.
  always_comb begin : arb_c
    int unsigned idx;
    logic [PTR_W-1:0] idx_p;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_p     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      idx_p = PTR_W'(idx);
      if (!win_found && req_s[idx_p]) begin
        win_found = 1'b1;
        win_idx   = idx_p;
      end
    end
  end

  // Pointer after the winner; explicit wrap keeps non-power-of-two N_REQ in range.
  assign win_next = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);

  // State register
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      ptr_q        <= '0;
      lfsr_reset_q <= 1'b1;
      grant_q      <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      lfsr_reset_q <= lfsr_reset_d;
      grant_q      <= grant_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
    end
  end

  // Next-state and output logic; grant/valid default low so each grant is a one-cycle pulse.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    lfsr_reset_d = 1'b0;
    grant_d      = '0;
    valid_d      = 1'b0;
    data_d       = data_q;

    if (reseed) begin
      // Reseed wins over any pending request and restarts the fill.
      state_d      = ST_INIT;
      lfsr_reset_d = 1'b1;
      cnt_d        = '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          // LFSR is reset at this edge by the still-high lfsr_reset.
          state_d = ST_FILL;
          cnt_d   = '0;
        end
        ST_FILL: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_READY: begin
          if (win_found) begin
            data_d  = lfsr_out;
            grant_d = N_REQ'(1) << win_idx;
            valid_d = 1'b1;
            ptr_d   = win_next;
            cnt_d   = '0;
            state_d = ST_FILL;
          end
        end
        default: begin
          state_d      = ST_INIT;
          lfsr_reset_d = 1'b1;
          cnt_d        = '0;
        end
      endcase
    end
  end

  assign lfsr_reset = lfsr_reset_q;
  assign bus.grant  = grant_q;
  assign bus.valid  = valid_q;
  assign bus.data   = data_q;

endmodule

// File: tb/tb_lfsr_word_arbiter.sv
// Bench for lfsr_word_arbiter: a behavioural LFSR stands in for the random
// source, a cycle-level freshness/round-robin model predicts every output.
module tb_lfsr_word_arbiter;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned REFRESH = 16;
  localparam logic [0:15] SEED    = 16'hACE1;

  logic              CLK = 1'b0;
  logic              reset_n = 1'b0;
  logic              reseed = 1'b0;
  logic              lfsr_reset;
  logic [0:15]       lfsr_out = SEED;
  logic              ro_bit = 1'b0;

  lfsr_word_arbiter_if #(.N_REQ(N_REQ)) bus ();

  lfsr_word_arbiter #(.N_REQ(N_REQ), .REFRESH(REFRESH)) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .reseed     (reseed),
    .lfsr_out   (lfsr_out),
    .lfsr_reset (lfsr_reset),
    .bus        (bus)
  );

  always #5 CLK = ~CLK;

  // x^16+x^14+x^13+x^11+1 with ring-oscillator bit mixed into the feedback
  function automatic logic [0:15] lfsr_next(input logic [0:15] s, input logic r);
    return {s[15] ^ s[13] ^ s[12] ^ s[10] ^ r, s[0:14]};
  endfunction

  always @(posedge CLK) begin
    if (lfsr_reset === 1'b1) lfsr_out <= SEED;
    else                     lfsr_out <= lfsr_next(lfsr_out, ro_bit);
  end

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // reference model state
  int               next_ok = 0;
  int               m_ptr = 0;
  logic [N_REQ-1:0] m_grant = '0;
  logic             m_valid = 1'b0;
  logic             m_lr = 1'b1;
  logic [0:15]      m_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  // Freshness model: a word may be handed out only once enough edges have
  // passed since reset, reseed or the previous word.
  task automatic model_edge(input logic rn, input logic rs, input logic [N_REQ-1:0] rq,
                            input logic [0:15] lf);
    int w;
    m_grant = '0;
    m_valid = 1'b0;
    if (!rn) begin
      m_lr    = 1'b1;
      m_data  = '0;
      m_ptr   = 0;
      next_ok = edge_n + REFRESH + 2;
    end else if (rs) begin
      m_lr    = 1'b1;
      next_ok = edge_n + REFRESH + 2;
    end else begin
      m_lr = 1'b0;
      if (edge_n >= next_ok && rq != '0) begin
        w = -1;
        for (int k = 0; k < N_REQ; k++) begin
          if (w < 0 && rq[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
        end
        m_grant = N_REQ'(1) << w;
        m_valid = 1'b1;
        m_data  = lf;
        m_ptr   = (w + 1) % N_REQ;
        next_ok = edge_n + REFRESH + 1;
      end
    end
  endtask

  // One clock: drive at negedge, model the edge, sample 1 time unit later.
  task automatic step(input logic rn, input logic rs, input logic [N_REQ-1:0] rq, input logic ro);
    logic [0:15] lf;
    @(negedge CLK);
    reset_n = rn;
    reseed  = rs;
    bus.req = rq;
    ro_bit  = ro;
    lf      = lfsr_out;
    @(posedge CLK);
    model_edge(rn, rs, rq, lf);
    #1;
    check("model_grant", 32'(bus.grant), 32'(m_grant));
    check("model_valid", 32'(bus.valid), 32'(m_valid));
    check("model_data", 32'(bus.data), 32'(m_data));
    check("model_lfsr_reset", 32'(lfsr_reset), 32'(m_lr));
    check("grant_onehot", 32'($countones(bus.grant) <= 1), 32'(1));
    check("valid_vs_grant", 32'(bus.valid), 32'(bus.grant != '0));
    edge_n++;
  endtask

  typedef struct {
    int         cycles;
    logic       rn;
    logic       rs;
    logic [3:0] rq;
    logic [3:0] g;
    logic       v;
    logic       lr;
  } vec_t;

  vec_t vecs[25];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [0:15]      exp_word;
    logic [N_REQ-1:0] pend;
    logic [N_REQ-1:0] rq;

    vecs[0]  = '{2,  1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[1]  = '{17, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
    vecs[2]  = '{1,  1'b1, 1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0};
    vecs[3]  = '{16, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
    vecs[4]  = '{1,  1'b1, 1'b0, 4'b1111, 4'b0010, 1'b1, 1'b0};
    vecs[5]  = '{16, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{1,  1'b1, 1'b0, 4'b1111, 4'b0100, 1'b1, 1'b0};
    vecs[7]  = '{16, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
    vecs[8]  = '{1,  1'b1, 1'b0, 4'b1111, 4'b1000, 1'b1, 1'b0};
    vecs[9]  = '{16, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
    vecs[10] = '{1,  1'b1, 1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0};
    vecs[11] = '{1,  1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[12] = '{17, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0};
    vecs[13] = '{1,  1'b1, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0};
    vecs[14] = '{40, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[15] = '{1,  1'b1, 1'b0, 4'b1001, 4'b1000, 1'b1, 1'b0};
    vecs[16] = '{16, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[17] = '{1,  1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1};
    vecs[18] = '{1,  1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0};
    vecs[19] = '{16, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0};
    vecs[20] = '{1,  1'b1, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0};
    vecs[21] = '{7,  1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[22] = '{1,  1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1};
    vecs[23] = '{17, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0};
    vecs[24] = '{1,  1'b1, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0};

    bus.req = '0;

    // Reset held with random requests: outputs stay at reset values.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, N_REQ'($urandom), 1'b0);
      check("reset_grant", 32'(bus.grant), 32'(0));
      check("reset_valid", 32'(bus.valid), 32'(0));
      check("reset_data", 32'(bus.data), 32'(0));
      check("reset_lfsr_reset", 32'(lfsr_reset), 32'(1));
    end

    // First word: only at E17, equal to seed advanced 16 times.
    exp_word = SEED;
    for (int i = 0; i < REFRESH; i++) exp_word = lfsr_next(exp_word, 1'b0);
    for (int e = 0; e <= 18; e++) begin
      step(1'b1, 1'b0, (e <= 17) ? N_REQ'(1) : N_REQ'(0), 1'b0);
      check($sformatf("first_valid_E%0d", e), 32'(bus.valid), 32'(e == 17));
      check($sformatf("first_grant_E%0d", e), 32'(bus.grant), (e == 17) ? 32'(1) : 32'(0));
      if (e == 17) check("first_data", 32'(bus.data), 32'(exp_word));
      if (e == 0) check("first_lfsr_reset_E0", 32'(lfsr_reset), 32'(0));
    end

    // Directed table: round robin, skip/idle, reseed priority, mid-fill reset.
    for (int i = 0; i < 25; i++) begin
      for (int c = 0; c < vecs[i].cycles; c++) begin
        step(vecs[i].rn, vecs[i].rs, N_REQ'(vecs[i].rq), 1'b0);
      end
      check($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(vecs[i].g));
      check($sformatf("vec%0d_valid", i), 32'(bus.valid), 32'(vecs[i].v));
      check($sformatf("vec%0d_lfsr_reset", i), 32'(lfsr_reset), 32'(vecs[i].lr));
    end

    // Randomised traffic with ring-oscillator mixing, reseeds and resets.
    pend = '0;
    for (int i = 0; i < 1500; i++) begin
      rq = pend;
      for (int r = 0; r < N_REQ; r++) begin
        if (!rq[r] && ($urandom % 4 == 0)) rq[r] = 1'b1;
        else if (rq[r] && ($urandom % 64 == 0)) rq[r] = 1'b0;
      end
      step(($urandom % 400) != 0, ($urandom % 150) == 0, rq, 1'($urandom));
      pend = rq & ~bus.grant;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
